// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_pkg
// Brief   : Shared widths, constants and the PWM compare helper.
// Revision: 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int PWM_CNT_W        = 8;
    localparam int N_OUTPUTS        = 16;
    localparam int DEFAULT_PRESCALE = 13;

    typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

    localparam pwm_cnt_t DUTY_FULL = 8'hFF;

    // Full-scale duty bypasses the compare so 0xFF never drops for a tick.
    function automatic logic pwm_level(input pwm_cnt_t cnt, input pwm_cnt_t duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module  : pwm_timebase
// Brief   : Prescaler and 8-bit PWM counter; exports tick, wrap, period_start.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int PRESCALE   = DEFAULT_PRESCALE,
    parameter int PRESCALE_W = 16
) (
    input  logic     clk,
    input  logic     rst,
    output pwm_cnt_t pwm_cnt_o,
    output logic     tick_o,
    output logic     wrap_o,
    output logic     period_start_o
);

    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] prescale_d;
    pwm_cnt_t              cnt_q;
    pwm_cnt_t              cnt_d;
    logic                  period_start_q;
    logic                  w_tick;
    logic                  w_wrap;

    always_comb begin
        w_tick     = (prescale_q == PRESCALE_LAST);
        w_wrap     = w_tick && (cnt_q == '1);
        prescale_d = w_tick ? '0 : prescale_q + 1'b1;
        cnt_d      = w_tick ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q     <= '0;
            cnt_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            prescale_q     <= prescale_d;
            cnt_q          <= cnt_d;
            period_start_q <= w_wrap;
        end
    end

    assign pwm_cnt_o      = cnt_q;
    assign tick_o         = w_tick;
    assign wrap_o         = w_wrap;
    assign period_start_o = period_start_q;

endmodule
`default_nettype wire

// File: rtl/pwm_peripheral.sv
`default_nettype none
// ============================================================================
// Module  : pwm_peripheral
// Brief   : 16 static/PWM user outputs from SPI config registers.
//           PWM_DUTY_SHADOW_EN: latch duty only at period boundaries.
// Revision: 1.0 - initial release
// ============================================================================
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int PRESCALE   = DEFAULT_PRESCALE,
    parameter int PRESCALE_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           en_reg_out_7_0,
    input  logic [7:0]           en_reg_out_15_8,
    input  logic [7:0]           en_reg_pwm_7_0,
    input  logic [7:0]           en_reg_pwm_15_8,
    input  logic [PWM_CNT_W-1:0] pwm_duty_cycle,
    output logic [N_OUTPUTS-1:0] out,
    output logic                 period_start
);

    pwm_cnt_t             w_pwm_cnt;
    pwm_cnt_t             w_duty_eff;
    logic                 w_tick;
    logic                 w_wrap;
    logic                 w_level;
    logic [N_OUTPUTS-1:0] w_en_out;
    logic [N_OUTPUTS-1:0] w_en_pwm;
    logic [N_OUTPUTS-1:0] out_q;
    logic [N_OUTPUTS-1:0] out_d;

    pwm_timebase #(
        .PRESCALE   (PRESCALE),
        .PRESCALE_W (PRESCALE_W)
    ) u_timebase (
        .clk            (clk),
        .rst            (rst),
        .pwm_cnt_o      (w_pwm_cnt),
        .tick_o         (w_tick),
        .wrap_o         (w_wrap),
        .period_start_o (period_start)
    );

`ifdef PWM_DUTY_SHADOW_EN
    pwm_cnt_t duty_q;
    pwm_cnt_t duty_d;
    logic     w_unused_tick;

    // Capture on the wrap edge so the new value governs the period that starts there.
    assign duty_d        = w_wrap ? pwm_duty_cycle : duty_q;
    assign w_unused_tick = w_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign w_duty_eff = duty_q;
`else
    logic w_unused_timebase;

    assign w_unused_timebase = w_tick ^ w_wrap;
    assign w_duty_eff        = pwm_duty_cycle;
`endif

    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign w_level  = pwm_level(w_pwm_cnt, w_duty_eff);

    // Static-mode bits are forced high; PWM-mode bits follow the shared level.
    always_comb begin
        out_d = w_en_out & (~w_en_pwm | {N_OUTPUTS{w_level}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
`default_nettype none
// ============================================================================
// Module  : tb_pwm_peripheral
// Brief   : Directed self-checking bench for pwm_peripheral (PRESCALE 13 and 1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pwm_peripheral;

    localparam int PER13 = 256 * 13;
    localparam int PER1  = 256;
`ifdef PWM_DUTY_SHADOW_EN
    localparam int T5_FIRST_HIGH = 64 * 13;
`else
    localparam int T5_FIRST_HIGH = 192 * 13;
`endif
    localparam int T5_SECOND_HIGH = 192 * 13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  en_out_lo = 8'h00;
    logic [7:0]  en_out_hi = 8'h00;
    logic [7:0]  en_pwm_lo = 8'h00;
    logic [7:0]  en_pwm_hi = 8'h00;
    logic [7:0]  duty = 8'h00;
    logic [15:0] out13;
    logic [15:0] out1;
    logic        ps13;
    logic        ps1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(.PRESCALE(13), .PRESCALE_W(16)) u_dut13 (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_out_lo),
        .en_reg_out_15_8 (en_out_hi),
        .en_reg_pwm_7_0  (en_pwm_lo),
        .en_reg_pwm_15_8 (en_pwm_hi),
        .pwm_duty_cycle  (duty),
        .out             (out13),
        .period_start    (ps13)
    );

    pwm_peripheral #(.PRESCALE(1), .PRESCALE_W(16)) u_dut1 (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_out_lo),
        .en_reg_out_15_8 (en_out_hi),
        .en_reg_pwm_7_0  (en_pwm_lo),
        .en_reg_pwm_15_8 (en_pwm_hi),
        .pwm_duty_cycle  (duty),
        .out             (out1),
        .period_start    (ps1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ps(input bit fast, input int budget, output int n);
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            step(1);
            n++;
            seen = fast ? ps1 : ps13;
        end
        if (!seen) chk("period_start_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        en_out_lo = eo[7:0];
        en_out_hi = eo[15:8];
        en_pwm_lo = ep[7:0];
        en_pwm_hi = ep[15:8];
    endtask

    initial begin
        int n;
        int highs;
        int mixed;
        int pscnt;
        int bad;

        // Reset state and first period after release
        set_en(16'hFFFF, 16'hFFFF);
        duty = 8'h80;
        step(3);
        chk("reset_out", {16'd0, out13}, 32'h0000);
        chk("reset_ps", {31'd0, ps13}, 32'd0);
        rst = 1'b0;
        wait_ps(1'b0, PER13 + 100, n);
        chk("first_period_start_delay", n, PER13);

        // Duty 0x80: 1664 clk high per 3328-clk period, rising 1 clk after period_start
        chk("out_at_period_start", {16'd0, out13}, 32'h0000);
        highs = 0;
        mixed = 0;
        pscnt = 0;
        for (int j = 1; j <= PER13; j++) begin
            step(1);
            if (j == 1) chk("rise_after_period_start", {16'd0, out13}, 32'hFFFF);
            if (out13 == 16'hFFFF) highs++;
            else if (out13 != 16'h0000) mixed++;
            if (ps13) pscnt++;
        end
        chk("duty80_high_clks", highs, 1664);
        chk("duty80_phase_aligned", mixed, 0);
        chk("period_start_once_per_period", pscnt, 1);

        // Asynchronous reset mid-period while outputs are high
        step(5);
        chk("out_high_before_rst", {16'd0, out13}, 32'hFFFF);
        rst = 1'b1;
        #1;
        chk("async_rst_out", {16'd0, out13}, 32'h0000);
        chk("async_rst_ps", {31'd0, ps13}, 32'd0);
        step(2);
        rst = 1'b0;

        // Static outputs and enable gating
        set_en(16'h0001, 16'h0000);
        step(1);
        chk("static_bit0", {16'd0, out13}, 32'h0001);
        set_en(16'h8000, 16'h0000);
        step(1);
        chk("static_bit15", {16'd0, out13}, 32'h8000);
        set_en(16'h0000, 16'hFFFF);
        duty = 8'hFF;
        step(1);
        chk("en_out_zero_forces_low", {16'd0, out13}, 32'h0000);

        // Duty 0x00 then 0xFF with mixed modes
        set_en(16'hFFFF, 16'h00FF);
        duty = 8'h00;
        wait_ps(1'b0, PER13 + 100, n);
        bad = 0;
        for (int j = 1; j <= PER13; j++) begin
            step(1);
            if (out13 != 16'hFF00) bad++;
        end
        chk("duty00_constant", bad, 0);
        duty = 8'hFF;
        wait_ps(1'b0, PER13 + 100, n);
        bad = 0;
        for (int j = 1; j <= 2 * PER13; j++) begin
            step(1);
            if (out13 != 16'hFFFF) bad++;
        end
        chk("dutyFF_no_low_glitch", bad, 0);

        // Duty change 0x40 -> 0xC0 when pwm_cnt reaches 0x20
        set_en(16'hFFFF, 16'hFFFF);
        duty = 8'h40;
        wait_ps(1'b0, PER13 + 100, n);
        highs = 0;
        for (int j = 1; j <= PER13; j++) begin
            step(1);
            if (out13[0]) highs++;
            if (j == 32 * 13) duty = 8'hC0;
        end
        chk("midperiod_change_high", highs, T5_FIRST_HIGH);
        highs = 0;
        for (int j = 1; j <= PER13; j++) begin
            step(1);
            if (out13[0]) highs++;
        end
        chk("next_period_high", highs, T5_SECOND_HIGH);

        // PRESCALE = 1 instance: 256-clk period, 1-clk pulse at duty 0x01
        duty = 8'h01;
        wait_ps(1'b1, PER1 + 20, n);
        wait_ps(1'b1, PER1 + 20, n);
        chk("prescale1_period", n, PER1);
        highs = 0;
        for (int j = 1; j <= PER1; j++) begin
            step(1);
            if (j == 1) chk("prescale1_pulse_position", {31'd0, out1[0]}, 32'd1);
            if (out1[0]) highs++;
        end
        chk("prescale1_duty01_high", highs, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
